// File: rtl/mr_wb_timer.sv
// Wishbone pipelined machine timer: 64-bit mtime/mtimecmp, prescaler, HI snapshot and
// registered interrupt. Responses come out two edges after acceptance.
module mr_wb_timer #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned PRESCALE_BITS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2:0]            adr_i,
  input  logic [XLEN-1:0]       dat_i,
  output logic [XLEN-1:0]       dat_o,
  input  logic                  we_i,
  input  logic [XLEN/8-1:0]     sel_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  stall_o,
  output logic                  irq_o
);

  localparam int NumBytes = XLEN / 8;
  localparam logic [PRESCALE_BITS-1:0] PcntOne = 1;

  logic [63:0]              mtime_q, mtime_d;
  logic [63:0]              mtimecmp_q, mtimecmp_d;
  logic                     en_q, en_d;
  logic [PRESCALE_BITS-1:0] div_q, div_d;
  logic [PRESCALE_BITS-1:0] pcnt_q, pcnt_d;
  logic [XLEN-1:0]          hi_snap_q, hi_snap_d;
  logic                     pend_q, pend_err_q;
  logic [XLEN-1:0]          pend_dat_q;

  logic                     req, wr, mapped, tick;
  logic [XLEN-1:0]          wmask, ctrl_word, ctrl_new, rd_data;

  assign stall_o = 1'b0;
  assign req     = cyc_i & stb_i;
  assign wr      = req & we_i & (sel_i != '0);
  assign mapped  = (adr_i <= 3'd5);
  assign tick    = en_q & (pcnt_q == div_q);

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old_val,
                                            input logic [XLEN-1:0] new_val,
                                            input logic [XLEN-1:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  always_comb begin
    for (int i = 0; i < NumBytes; i++) begin
      wmask[8*i +: 8] = {8{sel_i[i]}};
    end
    ctrl_word = '0;
    ctrl_word[0] = en_q;
    ctrl_word[8 +: PRESCALE_BITS] = div_q;
    ctrl_new = merge(ctrl_word, dat_i, wmask);
    case (adr_i)
      3'd0:    rd_data = mtime_q[31:0];
      3'd1:    rd_data = hi_snap_q;
      3'd2:    rd_data = mtimecmp_q[31:0];
      3'd3:    rd_data = mtimecmp_q[63:32];
      3'd4:    rd_data = ctrl_word;
      3'd5:    rd_data = {{(XLEN-1){1'b0}}, irq_o};
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    div_d      = div_q;
    hi_snap_d  = hi_snap_q;
    // A bus write to either mtime half suppresses that cycle's increment.
    if (wr && adr_i == 3'd0) begin
      mtime_d[31:0] = merge(mtime_q[31:0], dat_i, wmask);
    end else if (wr && adr_i == 3'd1) begin
      mtime_d[63:32] = merge(mtime_q[63:32], dat_i, wmask);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (req && !we_i && adr_i == 3'd0) begin
      hi_snap_d = mtime_q[63:32];
    end else if (wr && adr_i == 3'd1) begin
      hi_snap_d = merge(mtime_q[63:32], dat_i, wmask);
    end
    if (wr && adr_i == 3'd2) mtimecmp_d[31:0] = merge(mtimecmp_q[31:0], dat_i, wmask);
    if (wr && adr_i == 3'd3) mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], dat_i, wmask);
    if (wr && adr_i == 3'd4) begin
      en_d  = ctrl_new[0];
      div_d = ctrl_new[8 +: PRESCALE_BITS];
    end
    if (wr && adr_i == 3'd4) begin
      pcnt_d = '0;
    end else if (!en_q || pcnt_q == div_q) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PcntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      en_q       <= 1'b0;
      div_q      <= '0;
      pcnt_q     <= '0;
      hi_snap_q  <= '0;
      pend_q     <= 1'b0;
      pend_err_q <= 1'b0;
      pend_dat_q <= '0;
      ack_o      <= 1'b0;
      err_o      <= 1'b0;
      dat_o      <= '0;
      irq_o      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      div_q      <= div_d;
      pcnt_q     <= pcnt_d;
      hi_snap_q  <= hi_snap_d;
      pend_q     <= req;
      pend_err_q <= ~mapped;
      pend_dat_q <= (we_i || !mapped) ? '0 : rd_data;
      // A response is only delivered if the initiator still holds cyc_i.
      ack_o      <= pend_q & ~pend_err_q & cyc_i;
      err_o      <= pend_q & pend_err_q & cyc_i;
      dat_o      <= (pend_q && !pend_err_q && cyc_i) ? pend_dat_q : '0;
      irq_o      <= (mtime_q >= mtimecmp_q);
    end
  end

endmodule
